// File: rtl/encode_sched_pkg.sv
// -----------------------------------------------------------------------------
// encode_sched_pkg
// Shared types and constants for the encode scheduler block.
//   BLOCK_W  : width of one packed 8x8 block of signed 8-bit coefficients.
//   state_e  : scheduler FSM states (IDLE, RUN, RESP).
//   req_id_t : requester identifier (0 or 1).
// -----------------------------------------------------------------------------
package encode_sched_pkg;

    localparam int BLOCK_W = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant. The last-grant pointer is owned by
// the parent so that it only advances on an actual accept.
//   en_i          : grant permitted this cycle
//   valid_i[1:0]  : request lines, bit N belongs to requester N
//   last_grant_i  : requester granted most recently
//   grant_valid_o : a grant is issued this cycle
//   grant_id_o    : requester being granted (meaningful with grant_valid_o)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import encode_sched_pkg::*;
(
    input  logic       en_i,
    input  logic [1:0] valid_i,
    input  req_id_t    last_grant_i,
    output logic       grant_valid_o,
    output req_id_t    grant_id_o
);

    always_comb begin
        grant_valid_o = en_i & (|valid_i);
        // Contention goes to whoever was not served last; otherwise the
        // single active requester wins.
        if (valid_i == 2'b11) begin
            grant_id_o = ~last_grant_i;
        end else begin
            grant_id_o = valid_i[1];
        end
    end

endmodule

// File: rtl/encode_scheduler.sv
// -----------------------------------------------------------------------------
// encode_scheduler
// Shares one Huffman encode core between two block producers. Picks a block
// round-robin, holds Enable/A on the core until done (or timeout), captures C
// and returns it on a valid/ready response channel tagged with the owner id.
//   Clock, reset          : clock, synchronous active-low reset
//   reqN_valid/ready/block: requester N block channel (ready is combinational)
//   rsp_valid/ready       : response handshake
//   rsp_data/id/err       : encoded block, owner, timeout flag (data 0 on err)
//   enc_enable/a          : drive to the encode core
//   enc_c/done            : result from the encode core
//   busy                  : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module encode_scheduler #(
    parameter int BLOCK_W = encode_sched_pkg::BLOCK_W,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BLOCK_W-1:0] req0_block,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [BLOCK_W-1:0] req1_block,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BLOCK_W-1:0] rsp_data,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic               enc_enable,
    output logic [BLOCK_W-1:0] enc_a,
    input  logic [BLOCK_W-1:0] enc_c,
    input  logic               enc_done,
    output logic               busy
);

    import encode_sched_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    req_id_t            last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               enc_enable_q;
    logic [BLOCK_W-1:0] enc_a_q;
    logic               rsp_valid_q;
    logic [BLOCK_W-1:0] rsp_data_q;
    req_id_t            rsp_id_q;
    logic               rsp_err_q;
    logic               busy_q;

    logic               grant_valid;
    req_id_t            grant_id;
    logic [1:0]         req_ready_w;

    // A done still high in IDLE belongs to an earlier job; granting then
    // would let the stale pulse complete the new job immediately.
    rr_arbiter2 u_arb (
        .en_i          (reset & (state_q == IDLE) & ~enc_done),
        .valid_i       ({req1_valid, req0_valid}),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready_w[gi] = grant_valid & (grant_id == req_id_t'(gi));
    end

    assign req0_ready = req_ready_w[0];
    assign req1_ready = req_ready_w[1];

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            enc_enable_q <= 1'b0;
            enc_a_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        enc_a_q      <= grant_id ? req1_block : req0_block;
                        rsp_id_q     <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= '0;
                        enc_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // done has priority over an expiring timeout
                    if (enc_done) begin
                        rsp_data_q   <= enc_c;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        enc_enable_q <= 1'b0;
                        state_q      <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        enc_enable_q <= 1'b0;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign enc_enable = enc_enable_q;
    assign enc_a      = enc_a_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_encode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_encode_scheduler
// Self-checking bench: arbitration vector table, hand-written corner sequences
// and a randomized run, all watched by a job-level reference model.
// -----------------------------------------------------------------------------
module tb_encode_scheduler;

    localparam int BW = 512;
    localparam int TO = 64;

    logic          Clock = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, rsp_ready;
    logic [BW-1:0] req0_block, req1_block;
    logic          req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
    logic          enc_enable, enc_done, busy;
    logic [BW-1:0] rsp_data, enc_a, enc_c;

    always #5 Clock = ~Clock;

    encode_scheduler #(.BLOCK_W(BW), .TIMEOUT(TO)) dut (
        .Clock(Clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_block(req0_block),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_block(req1_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .enc_enable(enc_enable), .enc_a(enc_a), .enc_c(enc_c), .enc_done(enc_done),
        .busy(busy)
    );

    // Encode core model: done after core_lat further Enable cycles (never if
    // negative), C = A xor c_key; enc_stuck forces done high.
    int            core_lat;
    int            en_cnt = 0;
    logic          enc_stuck;
    logic [BW-1:0] c_key;

    always @(posedge Clock) en_cnt <= enc_enable ? en_cnt + 1 : 0;
    assign enc_done = enc_stuck | (enc_enable && (core_lat >= 0) && (en_cnt == core_lat));
    assign enc_c    = enc_a ^ c_key;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks one job at a time (idle / encoding / waiting
    // for the consumer). Expectations come from the model's own copy of the
    // accepted block, never from DUT outputs.
    // ------------------------------------------------------------------
    bit            chk_en = 0;
    int            m_phase = 0;     // 0 idle, 1 encoding, 2 response pending
    int            m_runs  = 0;     // encoding cycles already spent
    bit            m_last  = 1;
    logic [BW-1:0] m_a = '0, m_data = '0;
    bit            m_id = 0, m_err = 0;
    bit            ok_grant, pick;

    always @(negedge Clock) begin
        ok_grant = (m_phase == 0) && reset && !enc_done && (req0_valid || req1_valid);
        pick     = (req0_valid && req1_valid) ? !m_last : req1_valid;
        if (chk_en) begin
            check("m_busy",       busy,       m_phase != 0);
            check("m_enc_enable", enc_enable, m_phase == 1);
            check("m_rsp_valid",  rsp_valid,  m_phase == 2);
            check("m_req0_ready", req0_ready, ok_grant && !pick);
            check("m_req1_ready", req1_ready, ok_grant && pick);
            check("m_enc_a",      enc_a,      m_a);
            check("m_rsp_data",   rsp_data,   m_data);
            check("m_rsp_err",    rsp_err,    m_err);
            if (m_phase != 1) check("m_rsp_id", rsp_id, m_id);
        end
        if (!reset) begin
            m_phase = 0; m_last = 1; m_a = '0; m_data = '0; m_id = 0; m_err = 0; m_runs = 0;
        end else if (m_phase == 0) begin
            if (ok_grant) begin
                m_a = pick ? req1_block : req0_block;
                m_id = pick; m_last = pick; m_runs = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_runs++;
            if (enc_done) begin
                m_data = m_a ^ c_key; m_err = 0; m_phase = 2;
            end else if (m_runs == TO) begin
                m_data = '0; m_err = 1; m_phase = 2;
            end
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    end

    task automatic do_reset();
        @(posedge Clock); #1;
        reset = 0; req0_valid = 0; req1_valid = 0; enc_stuck = 0; rsp_ready = 1;
        @(posedge Clock); #1;
        reset = 1;
    endtask

    // Run one job end-to-end. n_rsp = cycles from accept to rsp_valid,
    // n_en = Enable-high cycles in that window.
    task automatic run_job(input bit id, input logic [BW-1:0] blk, input int lat,
                           output int n_rsp, output int n_en,
                           output logic [BW-1:0] data, output bit err, output bit rid);
        bit got = 0;
        core_lat = lat; rsp_ready = 1;
        n_rsp = 0; n_en = 0; data = '0; err = 0; rid = 0;
        if (id) begin req1_valid = 1; req1_block = blk; end
        else    begin req0_valid = 1; req0_block = blk; end
        for (int w = 0; w < 100 && !got; w++) begin
            @(negedge Clock);
            got = id ? req1_ready : req0_ready;
        end
        check("job_accept", got, 1'b1);
        @(posedge Clock); #1;
        req0_valid = 0; req1_valid = 0;
        n_rsp = 1; got = 0;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge Clock);
            if (enc_enable) n_en++;
            if (rsp_valid) begin
                got = 1; data = rsp_data; err = rsp_err; rid = rsp_id;
            end else n_rsp++;
        end
        check("job_rsp_seen", got, 1'b1);
        @(posedge Clock); #1;
    endtask

    task automatic wait_rsp();
        bit got = 0;
        rsp_ready = 1;
        for (int w = 0; w < 300 && !got; w++) begin
            @(negedge Clock);
            got = rsp_valid;
        end
        check("wait_rsp", got, 1'b1);
        @(posedge Clock); #1;
    endtask

    typedef struct {
        int pre;            // -1: fresh reset, else id of a job served first
        bit v0, v1, dn;
        bit r0, r1;
    } vec_t;

    vec_t          tv[10];
    int            nr, ne;
    logic [BW-1:0] d, blk;
    bit            e, rid;
    logic [BW-1:0] b0[4], b1[4];
    bit            order[$];

    initial begin
        tv[0] = '{-1, 0, 0, 0, 0, 0};
        tv[1] = '{-1, 1, 0, 0, 1, 0};
        tv[2] = '{-1, 0, 1, 0, 0, 1};
        tv[3] = '{-1, 1, 1, 0, 1, 0};
        tv[4] = '{-1, 1, 1, 1, 0, 0};
        tv[5] = '{ 0, 1, 1, 0, 0, 1};
        tv[6] = '{ 0, 1, 0, 0, 1, 0};
        tv[7] = '{ 1, 1, 1, 0, 1, 0};
        tv[8] = '{ 1, 0, 1, 1, 0, 0};
        tv[9] = '{ 1, 0, 1, 0, 0, 1};

        reset = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_block = '0; req1_block = '0;
        core_lat = 20; enc_stuck = 0; c_key = '1;
        @(posedge Clock); #1;
        chk_en = 1;
        check("reset_busy", busy, 1'b0);
        check("reset_enc_a", enc_a, '0);
        check("reset_rsp_data", rsp_data, '0);
        reset = 1;

        // Arbitration vectors
        foreach (tv[i]) begin
            do_reset();
            if (tv[i].pre >= 0) run_job(tv[i].pre[0], rand_blk(), 2, nr, ne, d, e, rid);
            @(posedge Clock); #1;
            req0_valid = tv[i].v0; req1_valid = tv[i].v1; enc_stuck = tv[i].dn;
            #2;
            check($sformatf("vec%0d_r0", i), req0_ready, tv[i].r0);
            check($sformatf("vec%0d_r1", i), req1_ready, tv[i].r1);
            #1;
            req0_valid = 0; req1_valid = 0; enc_stuck = 0;
        end

        // Single req0 job, done 20 cycles after Enable
        do_reset();
        blk = rand_blk();
        run_job(0, blk, 20, nr, ne, d, e, rid);
        check("t1_latency", nr, 22);
        check("t1_enable_cycles", ne, 21);
        check("t1_data", d, ~blk);
        check("t1_err", e, 1'b0);
        check("t1_id", rid, 1'b0);

        // Both requesters continuously valid, 4 blocks each
        do_reset();
        core_lat = 3; rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin b0[i] = rand_blk(); b1[i] = rand_blk(); end
        begin
            int i0 = 0, i1 = 0, k0 = 0, k1 = 0;
            bit a0, a1;
            order.delete();
            for (int c = 0; c < 500 && order.size() < 8; c++) begin
                req0_valid = (i0 < 4); req0_block = b0[i0 % 4];
                req1_valid = (i1 < 4); req1_block = b1[i1 % 4];
                @(negedge Clock);
                a0 = req0_valid & req0_ready; a1 = req1_valid & req1_ready;
                if (rsp_valid && rsp_ready) begin
                    order.push_back(rsp_id);
                    if (rsp_id) begin check("t2_data1", rsp_data, ~b1[k1 % 4]); k1++; end
                    else        begin check("t2_data0", rsp_data, ~b0[k0 % 4]); k0++; end
                end
                @(posedge Clock); #1;
                if (a0) i0++;
                if (a1) i1++;
            end
            req0_valid = 0; req1_valid = 0;
            check("t2_count", order.size(), 8);
            foreach (order[j]) check($sformatf("t2_order%0d", j), order[j], j % 2);
        end

        // Consumer stalls for 5 cycles
        do_reset();
        core_lat = 4; rsp_ready = 0;
        blk = rand_blk();
        req0_block = blk; req1_block = rand_blk();
        req0_valid = 1; req1_valid = 1;
        begin
            bit got = 0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge Clock);
                got = rsp_valid;
                if (!got) begin @(posedge Clock); #1; req0_valid = 0; end
            end
            check("t3_rsp_seen", got, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            check("t3_valid", rsp_valid, 1'b1);
            check("t3_data", rsp_data, ~blk);
            check("t3_id", rsp_id, 1'b0);
            check("t3_ready1", req1_ready, 1'b0);
            check("t3_busy", busy, 1'b1);
            @(posedge Clock); #1;
            if (k < 4) @(negedge Clock);
        end
        rsp_ready = 1;
        @(negedge Clock);
        check("t3_handshake", rsp_valid, 1'b1);
        @(posedge Clock); #1;
        @(negedge Clock);
        check("t3_next_accept", req1_ready, 1'b1);
        @(posedge Clock); #1;
        req1_valid = 0;
        wait_rsp();

        // Timeout, then a normal job
        do_reset();
        blk = rand_blk();
        run_job(1, blk, -1, nr, ne, d, e, rid);
        check("t4_latency", nr, TO + 1);
        check("t4_err", e, 1'b1);
        check("t4_data", d, '0);
        check("t4_id", rid, 1'b1);
        check("t4_enable_after", enc_enable, 1'b0);
        run_job(0, blk, 5, nr, ne, d, e, rid);
        check("t4_next_data", d, ~blk);
        check("t4_next_err", e, 1'b0);

        // Reset pulse mid-RUN
        do_reset();
        core_lat = 30;
        run_job(1, rand_blk(), 2, nr, ne, d, e, rid);
        begin
            int seen = 0;
            core_lat = 30;
            req1_block = rand_blk(); req0_valid = 1;
            @(posedge Clock); #1;
            req0_valid = 0;
            repeat (9) @(posedge Clock);
            #1 reset = 0;
            @(posedge Clock); #1 reset = 1;
            @(negedge Clock);
            check("t5_busy", busy, 1'b0);
            check("t5_enable", enc_enable, 1'b0);
            check("t5_enc_a", enc_a, '0);
            check("t5_rsp_valid", rsp_valid, 1'b0);
            check("t5_rsp_err", rsp_err, 1'b0);
            check("t5_rsp_id", rsp_id, 1'b0);
            check("t5_rsp_data", rsp_data, '0);
            for (int c = 0; c < 40; c++) begin
                @(negedge Clock);
                if (rsp_valid) seen++;
            end
            check("t5_no_rsp", seen, 0);
            @(posedge Clock); #1;
            req0_valid = 1; req1_valid = 1;
            @(negedge Clock);
            check("t5_first_r0", req0_ready, 1'b1);
            check("t5_first_r1", req1_ready, 1'b0);
            @(posedge Clock); #1;
            req0_valid = 0; req1_valid = 0;
            wait_rsp();
        end

        // Stale done blocks the grant
        do_reset();
        core_lat = 3;
        @(posedge Clock); #1;
        enc_stuck = 1; req1_valid = 1; req1_block = rand_blk();
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            check("t6_blocked", req1_ready, 1'b0);
        end
        @(posedge Clock); #1;
        enc_stuck = 0;
        @(negedge Clock);
        check("t6_grant", req1_ready, 1'b1);
        @(posedge Clock); #1;
        req1_valid = 0;
        wait_rsp();

        // Randomized traffic against the model
        do_reset();
        begin
            bit a0, a1;
            int rsp_n = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge Clock);
                a0 = req0_valid & req0_ready; a1 = req1_valid & req1_ready;
                if (rsp_valid && rsp_ready) rsp_n++;
                @(posedge Clock); #1;
                if (!req0_valid || a0) begin
                    req0_valid = ($urandom_range(0, 2) != 0); req0_block = rand_blk();
                end
                if (!req1_valid || a1) begin
                    req1_valid = ($urandom_range(0, 2) != 0); req1_block = rand_blk();
                end
                rsp_ready = ($urandom_range(0, 3) != 0);
                enc_stuck = ($urandom_range(0, 15) == 0);
                if (!enc_enable)
                    core_lat = ($urandom_range(0, 5) == 0) ? 70 : int'($urandom_range(0, 12));
            end
            check("rand_activity", rsp_n >= 20, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encode_scheduler.md
Name: encode_scheduler

Overview:
- Shares one Huffman `encode` core between two block producers, req0 and req1 (for example luma and chroma), each sending 8x8 blocks of signed 8-bit coefficients packed into 512 bits.
- Arbitrates round-robin, holds the core's Enable and A stable until done, captures C, and returns it on a valid/ready response channel tagged with the requester id.
- Aborts a job with an error flag if the core does not finish within a timeout.

Parameters:
- BLOCK_W, 512: width of one packed block (64 x 8 bits) on both A and C.
- TIMEOUT, 4096: maximum number of RUN cycles before the job is aborted.
- CNT_W, $clog2(TIMEOUT)+1: width of the timeout counter (derived).

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a block.
- req0_ready  out  1  requester 0 block accepted this cycle.
- req0_block  in  BLOCK_W  requester 0 coefficient block.
- req1_valid  in  1  requester 1 has a block.
- req1_ready  out  1  requester 1 block accepted this cycle.
- req1_block  in  BLOCK_W  requester 1 coefficient block.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  BLOCK_W  encoded output (captured C).
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  job timed out; rsp_data is 0.
- enc_enable  out  1  Enable to the encode core.
- enc_a  out  BLOCK_W  A input to the encode core.
- enc_c  in  BLOCK_W  C output from the encode core.
- enc_done  in  1  done from the encode core.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: enc_enable, enc_a, rsp_valid, rsp_data, rsp_id, rsp_err, busy, both readies.
  - Round-robin pointer last_grant=1, so req0 wins first. Timeout counter is 0.
  - Reset during RUN or RESP drops the in-flight job; no response is ever produced for it.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - Grant is allowed only when enc_done==0. A stale done blocks new work.
  - Selection: if exactly one reqN_valid is high, grant N. If both are high, grant the one != last_grant.
  - reqN_ready is combinational: (state==IDLE) & ~enc_done & grant==N.
  - On accept: latch reqN_block into enc_a, latch N into the id register, set last_grant=N, clear the counter, and go to RUN.
- RUN:
  - enc_enable=1 and enc_a are held stable; the counter increments each cycle.
  - If enc_done==1: capture enc_c into rsp_data, set rsp_err=0, and go to RESP. enc_enable is 0 from the next cycle.
  - Else if counter==TIMEOUT-1: set rsp_data=0, rsp_err=1, go to RESP, and drop enc_enable.
  - done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_err are held stable until rsp_ready==1, then go to IDLE.
  - No new request is accepted while in RESP; requesters stall via ready==0.
- Latency: accept at cycle t → enc_enable high from t+1. Core done at t+1+k → rsp_valid at t+2+k. The earliest next accept is the cycle after the response handshake.
- enc_a retains the last block after a job; it is not cleared except by reset.
- No arithmetic on data; blocks pass through bit-exact.

Decomposition:
- Package encode_sched_pkg:
  - BLOCK_W constant.
  - state enum {IDLE, RUN, RESP}.
  - 1-bit requester-id typedef.
- Sub-module rr_arbiter2:
  - Combinational 2-way round-robin grant from valid[1:0] and last_grant, gated by an enable input.
  - The pointer register stays in the parent.

Test Plan:
- Single req0 job, core model returns done 20 cycles after Enable, with C = A bit-inverted → one response with id=0, err=0, data=~A, rsp_valid exactly 22 cycles after accept, enc_enable high for exactly 21 cycles.
- req0 and req1 both continuously valid with 4 blocks each, rsp_ready=1 → accepted and response order is 0,1,0,1,0,1,0,1; each block pairs with its own encoded data.
- rsp_ready held 0 for 5 cycles after rsp_valid → rsp_valid/data/id stable throughout, both readies 0, busy=1; handshake on cycle 6, then next accept.
- TIMEOUT=64, core never asserts done → after 64 RUN cycles rsp_err=1, rsp_data=0, enc_enable=0; the next request is then served normally.
- reset pulled low for 1 cycle in mid-RUN → next cycle all outputs 0, state IDLE, no response for the dropped job; req0 is granted first afterwards.
- enc_done stuck high while req1_valid=1 in IDLE → req1_ready stays 0 until done falls; grant occurs in the first cycle with done==0.
